// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit add/subtract: one 4-bit slice per clock, LSB nibble first, carry chained between slices.
// Optional saturation of overflowed results when ADDSUB_SAT_EN is defined.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: start is sampled only in IDLE; done pulses for exactly one cycle
  // when result/c_out/ovf have just been loaded; busy is high while slices run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       b_x;
  logic [4:0]       nib_sum;
  logic             c_msb;
  logic             last_nib;
  logic [WIDTH-1:0] full_sum;

  // Operands shift right each step, so the active nibble is always bits [3:0].
  assign b_x      = b_q[3:0] ^ {4{op_q}};
  assign nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_x} + {4'b0, carry_q};
  // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
  assign c_msb    = nib_sum[3] ^ a_q[3] ^ b_x[3];
  assign full_sum = {nib_sum[3:0], shadow_q[WIDTH-1:4]};
  assign last_nib = (idx_q == IW'(NIB - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    op_d     = op_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shadow_d = full_sum;
        carry_d  = nib_sum[4];
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        idx_d    = idx_q + IW'(1);
        if (last_nib) begin
          idx_d   = '0;
          done_d  = 1'b1;
          c_out_d = nib_sum[4];
          ovf_d   = c_msb ^ nib_sum[4];
`ifdef ADDSUB_SAT_EN
          // a_q[3] is operand A's sign bit once the top nibble is in place.
          if (c_msb ^ nib_sum[4]) begin
            result_d = a_q[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            result_d = full_sum;
          end
`else
          result_d = full_sum;
`endif
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub (WIDTH=16).
module tb_nibble_serial_addsub;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;

  int n_checks;
  int n_fail;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
  end

  // Driver: issue one op, then watch a fixed window of negedges.
  // lat = posedges from the start-sampling edge (inclusive) to first done high.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int busy_n, output int done_n);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    lat    = 0;
    busy_n = 0;
    done_n = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        op    = ~o;
        a     = W'($urandom);
        b     = W'($urandom);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bn, dn;
    do_op(1'b0, 16'h1234, 16'h0FFF, lat, bn, dn);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL add_latency got=%0d exp=5", lat); end
    n_checks++; if (bn !== 4) begin n_fail++; $display("FAIL add_busy_cycles got=%0d exp=4", bn); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL add_done_pulses got=%0d exp=1", dn); end
    n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL add_result got=%h exp=2233", result); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL add_c_out got=%b exp=0", c_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_wrap();
    int lat, bn, dn;
    do_op(1'b0, 16'hFFFF, 16'h0001, lat, bn, dn);
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL wrap_done got=%0d exp=1", dn); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL wrap_result got=%h exp=0000", result); end
    n_checks++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL wrap_c_out got=%b exp=1", c_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_pos_overflow();
    int lat, bn, dn;
    logic [W-1:0] exp_r;
`ifdef ADDSUB_SAT_EN
    exp_r = 16'h7FFF;
`else
    exp_r = 16'h8000;
`endif
    do_op(1'b0, 16'h7FFF, 16'h0001, lat, bn, dn);
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL povf_done got=%0d exp=1", dn); end
    n_checks++; if (result !== exp_r) begin n_fail++; $display("FAIL povf_result got=%h exp=%h", result, exp_r); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL povf_c_out got=%b exp=0", c_out); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL povf_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_subtract();
    int lat, bn, dn;
    logic [W-1:0] exp_r;
    do_op(1'b1, 16'h0005, 16'h0007, lat, bn, dn);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub1_latency got=%0d exp=5", lat); end
    n_checks++; if (result !== 16'hFFFE) begin n_fail++; $display("FAIL sub1_result got=%h exp=fffe", result); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL sub1_c_out got=%b exp=0", c_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub1_ovf got=%b exp=0", ovf); end
`ifdef ADDSUB_SAT_EN
    exp_r = 16'h8000;
`else
    exp_r = 16'h7FFF;
`endif
    do_op(1'b1, 16'h8000, 16'h0001, lat, bn, dn);
    n_checks++; if (result !== exp_r) begin n_fail++; $display("FAIL sub2_result got=%h exp=%h", result, exp_r); end
    n_checks++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL sub2_c_out got=%b exp=1", c_out); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sub2_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bn, dn;
    int dn_abort;
    dn_abort = 0;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h4321;
    b     = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    // Second RUN cycle: abort here.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got=%h exp=0000", result); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn_abort++;
    end
    n_checks++; if (dn_abort !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dn_abort); end
    do_op(1'b0, 16'h0A0A, 16'h0505, lat, bn, dn);
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL midrst_next_done got=%0d exp=1", dn); end
    n_checks++; if (result !== 16'h0F0F) begin n_fail++; $display("FAIL midrst_next_result got=%h exp=0f0f", result); end
  endtask

  task automatic test_start_ignored();
    int dn, bn;
    dn = 0;
    bn = 0;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h0100;
    b     = 16'h0023;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) dn++;
      // i==2 lands in RUN, i==5 lands in DONE; both must be ignored.
      if (i == 2 || i == 5) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 16'h7777;
        b     = 16'h1111;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got=%0d exp=1", dn); end
    n_checks++; if (bn !== 4) begin n_fail++; $display("FAIL ignore_busy_cycles got=%0d exp=4", bn); end
    n_checks++; if (result !== 16'h0123) begin n_fail++; $display("FAIL ignore_result got=%h exp=0123", result); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end got=%b exp=0", busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_wrap();
    test_pos_overflow();
    test_subtract();
    test_reset_mid_op();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-nibble add/subtract engine built around the team's 4-bit add/sub slice behaviour (op=0 add, op=1 subtract via invert-B plus carry-in).
- Accepts WIDTH-bit signed operands and processes one 4-bit nibble per clock, LSB nibble first, chaining carry between slices.
- Produces a registered WIDTH-bit result with carry-out and signed-overflow flags.
- Sits upstream of result consumers and downstream of operand sources; replaces a combinational WIDTH-bit adder where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  signed operand A; captured with start.
- b  input  WIDTH  signed operand B; captured with start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when result/flags are updated.
- result  output  WIDTH  registered result; held until next done.
- c_out  output  1  carry out of MSB nibble (subtract: 1 = no borrow).
- ovf  output  1  signed overflow of the full-width operation.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, c_out=0, ovf=0, nibble index=0, internal operand/carry registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - With start=1 at a rising edge, capture a, b, op.
  - Set carry register = op and nibble index = 0, then go to RUN.
  - start=0 stays in IDLE.
- RUN: one nibble k per cycle, k=0..NIB-1.
  - Compute {carry, s_k} = a_k + (b_k XOR {4{op}}) + carry.
  - Store s_k into a shadow register.
  - Record the carry into bit 3 of the top nibble for overflow.
  - After k=NIB-1, go to DONE.
- DONE (1 cycle):
  - result <= shadow, c_out <= final carry, ovf <= carry-into-MSB XOR carry-out; all three update on the edge entering DONE.
  - done=1 for this cycle only, then return to IDLE.
- busy=1 exactly in RUN (NIB cycles); done=1 exactly in DONE.
- Latency: start-sampling edge to done high = NIB+1 edges; throughput one op per NIB+2 cycles.
- start while in RUN or DONE is ignored; no queuing. Changes on a/b/op after capture have no effect.
- result, c_out and ovf change only on entry to DONE; intermediate nibbles are never visible on result.
- Wrap-around: result is modulo 2^WIDTH; c_out follows unsigned carry semantics.
- Reset mid-RUN: the operation is aborted, all outputs go to reset values immediately, and no done pulse is issued.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: when overflow is detected, result saturates to 0111..1 if operand A's sign bit is 0, else 1000..0. ovf is still reported and c_out is unchanged.
- Undefined: result is the wrapped two's-complement value. No saturation logic is present.

Test Plan:
- Reset mid-op: assert start, then drop rst_n during the 2nd RUN cycle -> busy=0, result=0, no done pulse; the next op completes normally.
- Add (WIDTH=16): op=0, a=0x1234, b=0x0FFF -> done after 5 edges with result=0x2233, c_out=0, ovf=0; busy high exactly 4 cycles.
- Unsigned wrap: op=0, a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1, ovf=0.
- Positive overflow: op=0, a=0x7FFF, b=0x0001 -> ovf=1, c_out=0, result=0x8000 (0x7FFF with ADDSUB_SAT_EN).
- Subtract:
  - op=1, a=0x0005, b=0x0007 -> result=0xFFFE, c_out=0, ovf=0.
  - op=1, a=0x8000, b=0x0001 -> result=0x7FFF, c_out=1, ovf=1 (0x8000 with ADDSUB_SAT_EN).
- Start ignored while busy: pulse start again during RUN with different operands -> the first result is unaffected; exactly one done pulse; busy returns to 0.
